// File: rtl/pipeline_reg_chain.sv
// pipeline_reg_chain: DEPTH-stage register chain carrying {data, rd, wen}.
// It has per-stage valid bits and valid/ready backpressure. Bubbles
// collapse, so an entry moves forward whenever the stage ahead is empty or
// is emptying.
// Optional feature macro: PIPE_FWD_EN adds rs1_fwd_data/rs2_fwd_data, which
// forward the payload of the youngest valid stage matching each query.
module pipeline_reg_chain #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 3,
    parameter int REG_BITS = 5,
    // Derived occupancy-counter width; leave at its default.
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [REG_BITS-1:0] in_rd,
    input  logic                in_wen,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [REG_BITS-1:0] out_rd,
    output logic                out_wen,
    input  logic [REG_BITS-1:0] query_rs1,
    input  logic [REG_BITS-1:0] query_rs2,
    output logic                rs1_hit,
    output logic                rs2_hit,
    output logic [CW-1:0]       count
`ifdef PIPE_FWD_EN
    ,
    output logic [WIDTH-1:0]    rs1_fwd_data,
    output logic [WIDTH-1:0]    rs2_fwd_data
`endif
);

    logic [DEPTH-1:0]    v_q, v_d;
    logic [DEPTH-1:0]    wen_q, wen_d;
    logic [WIDTH-1:0]    data_q [DEPTH];
    logic [WIDTH-1:0]    data_d [DEPTH];
    logic [REG_BITS-1:0] rd_q   [DEPTH];
    logic [REG_BITS-1:0] rd_d   [DEPTH];
    logic [CW-1:0]       count_q, count_d;

    logic [DEPTH-1:0]    adv;
    logic                stall;
    logic                in_fire, out_fire;
    logic [DEPTH-1:0]    match1, match2;

    // Advance flags, from tail to head: a stage moves unless every stage
    // ahead of it is full and the tail is stalled.
    always_comb begin
        adv   = '0;
        stall = ~out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = v_q[i] & ~stall;
            stall  = stall & v_q[i];
        end
    end

    assign in_ready  = ~flush & (~v_q[0] | adv[0]);
    assign out_valid = ~flush & v_q[DEPTH-1];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_data  = data_q[DEPTH-1];
    assign out_rd    = rd_q[DEPTH-1];
    assign out_wen   = wen_q[DEPTH-1];
    assign count     = count_q;

    // Next state: shift on advance. Emptied stages drop only their valid
    // bit, and flush clears all valid bits and the counter.
    always_comb begin
        v_d     = v_q;
        wen_d   = wen_q;
        data_d  = data_q;
        rd_d    = rd_q;
        count_d = count_q;
        for (int i = DEPTH - 1; i >= 1; i--) begin
            if (adv[i-1]) begin
                v_d[i]    = 1'b1;
                data_d[i] = data_q[i-1];
                rd_d[i]   = rd_q[i-1];
                wen_d[i]  = wen_q[i-1];
            end else if (adv[i]) begin
                v_d[i] = 1'b0;
            end
        end
        if (in_fire) begin
            v_d[0]    = 1'b1;
            data_d[0] = in_data;
            rd_d[0]   = in_rd;
            wen_d[0]  = in_wen;
        end else if (adv[0]) begin
            v_d[0] = 1'b0;
        end
        if (in_fire && !out_fire) begin
            count_d = count_q + CW'(1);
        end else if (!in_fire && out_fire) begin
            count_d = count_q - CW'(1);
        end
        if (flush) begin
            v_d     = '0;
            count_d = '0;
        end
    end

    // State registers; reset clears payload as well as control.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q     <= '0;
            wen_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
        end else begin
            v_q     <= v_d;
            wen_q   <= wen_d;
            count_q <= count_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    // Destination-hazard match per stage; register 0 never matches.
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = v_q[i] & wen_q[i] & (rd_q[i] == query_rs1) & (query_rs1 != '0);
            match2[i] = v_q[i] & wen_q[i] & (rd_q[i] == query_rs2) & (query_rs2 != '0);
        end
    end

    assign rs1_hit = |match1;
    assign rs2_hit = |match2;

`ifdef PIPE_FWD_EN
    // Priority mux: the lowest-index (youngest) matching stage wins.
    always_comb begin
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match1[i]) rs1_fwd_data = data_q[i];
            if (match2[i]) rs2_fwd_data = data_q[i];
        end
    end
`endif

endmodule
